// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit and its return-address stack.
package pc_pkg;

  typedef enum logic [1:0] {
    JUMP = 2'd0,
    CALL = 2'd1,
    RET  = 2'd2,
    RSVD = 2'd3
  } redir_kind_t;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_t;

  // Number of low address bits that must be zero for a STEP-aligned target.
  function automatic int unsigned align_bits(input int unsigned step);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) == step) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [CNT_W-1:0] cnt;

  // wp always points one past the newest entry, so overwrite-on-full falls out of the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (push) begin
      wp <= wp + PTR_W'(1);
      if (cnt != CNT_W'(DEPTH)) cnt <= cnt + CNT_W'(1);
    end else if (pop && (cnt != '0)) begin
      wp  <= wp - PTR_W'(1);
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wp] <= push_data;
  end

  assign top   = mem[wp - PTR_W'(1)];
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: sequential fetch with handshake, redirect/trap arbitration and RAS prediction.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned       XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_VEC = 32'h0000_0000,
  parameter int unsigned       STEP      = 4,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            fetch_ready_i,
  input  logic            redir_valid_i,
  input  logic [1:0]      redir_kind_i,
  input  logic [XLEN-1:0] redir_target_i,
  input  logic [XLEN-1:0] redir_link_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic [XLEN-1:0] pc_o,
  output logic            fetch_valid_o,
  output logic            misalign_o,
  output logic            ras_empty_o
);

  localparam int unsigned     ALIGN_BITS = align_bits(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [XLEN-1:0] STEP_X     = XLEN'(STEP);

  pc_state_t       state_q, state_d;
  redir_kind_t     kind;
  logic [XLEN-1:0] pc_d, tgt, ras_top;
  logic            valid_d, mis_d, load;
  logic            ras_push, ras_pop, ras_flush, ras_empty, ras_full_unused;

  assign kind = redir_kind_t'(redir_kind_i);

  ras_stack #(
    .WIDTH(XLEN),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .flush     (ras_flush),
    .push_data (redir_link_i),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_o          <= RESET_VEC;
      fetch_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_o          <= pc_d;
      fetch_valid_o <= valid_d;
      misalign_o    <= mis_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_o;
    valid_d   = 1'b0;
    mis_d     = 1'b0;
    load      = 1'b0;
    tgt       = '0;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_flush = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = !stall_i;
      end
      RUN: begin
        valid_d = !stall_i;
        if (trap_i) begin
          load      = 1'b1;
          tgt       = trap_vec_i;
          ras_flush = 1'b1;
        end else if (redir_valid_i) begin
          load = 1'b1;
          tgt  = redir_target_i;
          unique case (kind)
            CALL: ras_push = 1'b1;
            RET: begin
              if (!ras_empty) begin
                tgt     = ras_top;
                ras_pop = 1'b1;
              end
            end
            default: ;
          endcase
        end else if (!(stall_i || (fetch_valid_o && !fetch_ready_i))) begin
          pc_d = pc_o + STEP_X;
        end
        // Popped return addresses go through the same alignment check as any other target.
        if (load) begin
          pc_d  = tgt & ~ALIGN_MASK;
          mis_d = |(tgt & ALIGN_MASK);
        end
      end
    endcase
  end

  assign ras_empty_o = ras_empty;

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit: expectations queued at drive time, popped after each edge.
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        fetch_ready_i;
  logic        redir_valid_i;
  logic [1:0]  redir_kind_i;
  logic [31:0] redir_target_i;
  logic [31:0] redir_link_i;
  logic        trap_i;
  logic [31:0] trap_vec_i;
  logic [31:0] pc_o;
  logic        fetch_valid_o;
  logic        misalign_o;
  logic        ras_empty_o;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        v;
    logic        m;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  pc_unit #(
    .XLEN      (32),
    .RESET_VEC (32'h0000_0100),
    .STEP      (4),
    .RAS_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .fetch_ready_i  (fetch_ready_i),
    .redir_valid_i  (redir_valid_i),
    .redir_kind_i   (redir_kind_i),
    .redir_target_i (redir_target_i),
    .redir_link_i   (redir_link_i),
    .trap_i         (trap_i),
    .trap_vec_i     (trap_vec_i),
    .pc_o           (pc_o),
    .fetch_valid_o  (fetch_valid_o),
    .misalign_o     (misalign_o),
    .ras_empty_o    (ras_empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc,
                            input logic v, input logic m, input logic e);
    exp_t x;
    x.tag = tag; x.pc = pc; x.v = v; x.m = m; x.e = e;
    sb.push_back(x);
  endtask

  task automatic check_now();
    exp_t x;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      x = sb.pop_front();
      cmp({x.tag, ".pc"},    pc_o,                  x.pc);
      cmp({x.tag, ".valid"}, {31'd0, fetch_valid_o}, {31'd0, x.v});
      cmp({x.tag, ".mis"},   {31'd0, misalign_o},    {31'd0, x.m});
      cmp({x.tag, ".empty"}, {31'd0, ras_empty_o},   {31'd0, x.e});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic redir(input logic v, input logic [1:0] k,
                       input logic [31:0] t, input logic [31:0] l);
    redir_valid_i  = v;
    redir_kind_i   = k;
    redir_target_i = t;
    redir_link_i   = l;
  endtask

  initial begin
    rst = 1'b1;
    stall_i = 1'b0;
    fetch_ready_i = 1'b1;
    trap_i = 1'b0;
    trap_vec_i = '0;
    redir(1'b0, 2'd0, 32'h0, 32'h0);

    #2;
    expect_out("reset", 32'h100, 1'b0, 1'b0, 1'b1);
    check_now();

    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_out("boot", 32'h100, 1'b0, 1'b0, 1'b1);
    check_now();

    expect_out("run0", 32'h100, 1'b1, 1'b0, 1'b1); tick();
    expect_out("run1", 32'h104, 1'b1, 1'b0, 1'b1); tick();
    expect_out("run2", 32'h108, 1'b1, 1'b0, 1'b1); tick();

    fetch_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out("notready", 32'h108, 1'b1, 1'b0, 1'b1); tick();
    end
    fetch_ready_i = 1'b1;
    expect_out("ready", 32'h10C, 1'b1, 1'b0, 1'b1); tick();

    redir(1'b1, 2'd1, 32'h400, 32'h110);
    expect_out("call", 32'h400, 1'b1, 1'b0, 1'b0); tick();
    redir(1'b1, 2'd2, 32'hDEAD, 32'h0);
    expect_out("ret", 32'h110, 1'b1, 1'b0, 1'b1); tick();

    for (int i = 1; i <= 5; i++) begin
      redir(1'b1, 2'd1, 32'h500 + 32'(i) * 32'h10, 32'h1000 + 32'(i) * 32'h10);
      expect_out("call5", 32'h500 + 32'(i) * 32'h10, 1'b1, 1'b0, 1'b0); tick();
    end
    for (int i = 5; i >= 2; i--) begin
      redir(1'b1, 2'd2, 32'h7000, 32'h0);
      expect_out("ret5", 32'h1000 + 32'(i) * 32'h10, 1'b1, 1'b0, (i == 2)); tick();
    end
    redir(1'b1, 2'd2, 32'h7000, 32'h0);
    expect_out("ret_empty", 32'h7000, 1'b1, 1'b0, 1'b1); tick();

    redir(1'b1, 2'd1, 32'h600, 32'h1234);
    expect_out("call_pre_trap", 32'h600, 1'b1, 1'b0, 1'b0); tick();
    redir(1'b1, 2'd0, 32'h900, 32'h0);
    trap_i = 1'b1;
    trap_vec_i = 32'h80;
    expect_out("trap", 32'h80, 1'b1, 1'b0, 1'b1); tick();
    trap_i = 1'b0;
    redir(1'b1, 2'd2, 32'h640, 32'h0);
    expect_out("ret_flushed", 32'h640, 1'b1, 1'b0, 1'b1); tick();

    redir(1'b1, 2'd0, 32'h203, 32'h0);
    expect_out("jump_mis", 32'h200, 1'b1, 1'b1, 1'b1); tick();
    redir(1'b0, 2'd0, 32'h0, 32'h0);
    expect_out("mis_clear", 32'h204, 1'b1, 1'b0, 1'b1); tick();

    stall_i = 1'b1;
    expect_out("stall0", 32'h204, 1'b0, 1'b0, 1'b1); tick();
    expect_out("stall1", 32'h204, 1'b0, 1'b0, 1'b1); tick();
    stall_i = 1'b0;
    redir(1'b1, 2'd3, 32'hFFFF_FFFC, 32'h0);
    expect_out("rsvd_jump", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1); tick();
    redir(1'b0, 2'd0, 32'h0, 32'h0);
    expect_out("wrap", 32'h0, 1'b1, 1'b0, 1'b1); tick();

    redir(1'b1, 2'd1, 32'h3F0, 32'h44);
    expect_out("call_3f0", 32'h3F0, 1'b1, 1'b0, 1'b0); tick();
    redir(1'b0, 2'd0, 32'h0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    expect_out("async_rst", 32'h100, 1'b0, 1'b0, 1'b1);
    check_now();
    @(negedge clk);
    rst = 1'b0;
    expect_out("rerun", 32'h100, 1'b1, 1'b0, 1'b1); tick();
    expect_out("rerun1", 32'h104, 1'b1, 1'b0, 1'b1); tick();

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle and pipelined CPU cores. It replaces the bare PC register with a block that owns sequential increment, stall, and the fetch valid/ready handshake. It also arbitrates branch/jump redirects, traps, and call/return prediction through a small return-address stack (RAS). It sits at the front of the fetch stage and drives the instruction-memory address.

## Interface
Parameters:
- XLEN, 32, address width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- STEP, 4, sequential increment in bytes; must be a power of two ≥ 1.
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold the PC; no sequential advance.
- fetch_ready_i  in  1  instruction memory accepts pc_o this cycle.
- redir_valid_i  in  1  redirect request from execute.
- redir_kind_i  in  2  0 JUMP (branch/jump), 1 CALL, 2 RET, 3 reserved (treated as JUMP).
- redir_target_i  in  XLEN  redirect target; also the RET fallback when the RAS is empty.
- redir_link_i  in  XLEN  return address pushed on CALL.
- trap_i  in  1  trap request.
- trap_vec_i  in  XLEN  trap handler address.
- pc_o  out  XLEN  current fetch address; reset value RESET_VEC.
- fetch_valid_o  out  1  pc_o is a valid fetch request; reset value 0.
- misalign_o  out  1  one-cycle pulse when an accepted target had nonzero bits [log2(STEP)-1:0]; reset value 0.
- ras_empty_o  out  1  RAS holds no entries; reset value 1.

## Operation
State machine, two states: BOOT and RUN.
- BOOT is entered on reset. In BOOT, pc_o = RESET_VEC and fetch_valid_o = 0. The unit moves to RUN unconditionally on the next clk edge.
- In RUN, fetch_valid_o = 1 whenever the unit is not stalled.

Next-PC priority, evaluated only in RUN, highest first:
1. trap_i: pc ← trap_vec_i. The RAS is flushed (count ← 0). Any redirect in the same cycle is ignored.
2. redir_valid_i, by kind:
   - JUMP: pc ← redir_target_i.
   - CALL: pc ← redir_target_i and push redir_link_i.
   - RET with RAS non-empty: pc ← top of stack, then pop.
   - RET with RAS empty: pc ← redir_target_i; no pop.
3. stall_i, or fetch_valid_o && !fetch_ready_i: pc holds.
4. Otherwise pc ← pc + STEP.

Rules common to all cases:
- Redirects and traps take effect regardless of stall_i and fetch_ready_i; they squash the pending fetch.
- Every loaded target is aligned: bits [log2(STEP)-1:0] are forced to 0. misalign_o pulses for one cycle if the raw target had any of those bits set.
- Addition is modulo 2^XLEN: all-ones minus (STEP-1) wraps to 0 silently.

RAS behaviour:
- The RAS is circular.
- A push when full overwrites the oldest entry; count stays at RAS_DEPTH.
- A pop when empty does nothing.
- Only CALL pushes and only RET pops, so push and pop never happen in the same cycle.

## Timing
- All outputs are registered. A request sampled at edge N is visible on pc_o after edge N.
- Redirect and trap latency is exactly 1 cycle. Sequential advance happens 1 cycle after the handshake completes.
- Reset: pc_o = RESET_VEC, fetch_valid_o = 0, misalign_o = 0, RAS count = 0. This takes effect immediately on rst assertion, mid-operation included.
- After rst deasserts, the first edge leaves BOOT. fetch_valid_o rises after that edge, with pc_o = RESET_VEC.
- While stalled, fetch_valid_o = 0 and pc_o is stable.

## Structure
- Shared package pc_pkg holds:
  - the redir_kind_t enum (JUMP, CALL, RET, RSVD);
  - the state enum (BOOT, RUN);
  - the ALIGN_BITS helper constant derived from STEP.
- One sub-module, ras_stack, parametrised by width and depth. It has push, pop, push data, top, empty and full; it performs the overwrite-on-full behaviour internally.

## Test plan
- Reset then free-run with fetch_ready_i = 1 and RESET_VEC = 0x100 → pc_o = 0x100, then 0x104 and 0x108 on successive cycles; fetch_valid_o = 0 during BOOT only.
- fetch_ready_i = 0 for 3 cycles at pc 0x108 → pc_o holds 0x108; it advances to 0x10C on the first ready cycle.
- CALL to 0x400 with link 0x110, then RET with target 0xDEAD → pc_o = 0x400, then 0x110; ras_empty_o returns to 1.
- 5 CALLs with RAS_DEPTH = 4 (links L1..L5), then 5 RETs → pops L5, L4, L3, L2; the 5th RET uses redir_target_i.
- trap_i and a JUMP in the same cycle, with trap_vec_i = 0x80 → pc_o = 0x80 and the RAS is flushed. A JUMP to 0x203 → pc_o = 0x200 and misalign_o pulses for 1 cycle.
- Assert rst mid-run at pc 0x3F0 → pc_o = RESET_VEC immediately, with no clock edge required.
